// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default widths and the
// arbiter FSM state encoding.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker.
// req/mask in, ptr = favoured id on a tie; gnt_id = winner, any = someone won.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       ptr,
  output logic       gnt_id,
  output logic       any
);

  logic [1:0] eff;

  always_comb begin
    eff    = req & ~mask;
    any    = |eff;
    gnt_id = 1'b0;
    if (eff == 2'b11)
      gnt_id = ptr;
    else
      gnt_id = eff[1];
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin pick, one EXEC
// cycle on latched operands, registered result with a VALID pulse.
// Ports: CLK/RESET, REQn/OPn/An/Bn in, GNTn/VALIDn/RES_OUT/ERR/BUSY out,
// ALU_DATA1/ALU_DATA2/ALU_SELECT to the ALU, ALU_RESULT back from it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [SEL_W-1:0]  OP0,
  input  logic [SEL_W-1:0]  OP1,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] B1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              VALID0,
  output logic              VALID1,
  output logic [DATA_W-1:0] RES_OUT,
  output logic              ERR,
  output logic              BUSY,
  output logic [DATA_W-1:0] ALU_DATA1,
  output logic [DATA_W-1:0] ALU_DATA2,
  output logic [SEL_W-1:0]  ALU_SELECT,
  input  logic [DATA_W-1:0] ALU_RESULT
);

  state_t            state_q;
  state_t            state_d;
  logic              take;
  logic              id_q;
  logic              ptr_q;
  logic [SEL_W-1:0]  op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              err_q;

  logic [1:0]        mask;
  logic              gnt_id;
  logic              any;
  logic              rsvd;

  // The requester just served is still raising REQ in RESP;
  // keep it out of the next pick.
  assign mask = (state_q == RESP) ?
                (id_q ? 2'b10 : 2'b01) : 2'b00;

  rr_arb2 u_arb (
    .req    ({REQ1, REQ0}),
    .mask   (mask),
    .ptr    (ptr_q),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // Opcodes above OR (1xx) are reserved.
  assign rsvd = |op_q[SEL_W-1:2];

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          take    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (any) begin
          take    = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        id_q  <= gnt_id;
        ptr_q <= ~gnt_id;
        op_q  <= gnt_id ? OP1 : OP0;
        a_q   <= gnt_id ? A1 : A0;
        b_q   <= gnt_id ? B1 : B0;
      end
      if (state_q == EXEC) begin
        res_q <= rsvd ? '0 : ALU_RESULT;
        err_q <= rsvd;
      end
    end
  end

  assign BUSY       = (state_q == EXEC) ||
                      (state_q == RESP);
  assign GNT0       = (state_q == EXEC) && !id_q;
  assign GNT1       = (state_q == EXEC) && id_q;
  assign VALID0     = (state_q == RESP) && !id_q;
  assign VALID1     = (state_q == RESP) && id_q;
  assign RES_OUT    = res_q;
  assign ERR        = err_q;
  assign ALU_DATA1  = a_q;
  assign ALU_DATA2  = b_q;
  assign ALU_SELECT = rsvd ? '0 : op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table,
// hand sequences for reset/arbitration, and a randomized run.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic       gnt0, gnt1, valid0, valid1;
  logic [7:0] res_out;
  logic       err, busy;
  logic [7:0] d1, d2;
  logic [2:0] sel;
  logic [7:0] alu_res;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .CLK        (clk),
    .RESET      (rst),
    .REQ0       (req0),
    .REQ1       (req1),
    .OP0        (op0),
    .OP1        (op1),
    .A0         (a0),
    .A1         (a1),
    .B0         (b0),
    .B1         (b1),
    .GNT0       (gnt0),
    .GNT1       (gnt1),
    .VALID0     (valid0),
    .VALID1     (valid1),
    .RES_OUT    (res_out),
    .ERR        (err),
    .BUSY       (busy),
    .ALU_DATA1  (d1),
    .ALU_DATA2  (d2),
    .ALU_SELECT (sel),
    .ALU_RESULT (alu_res)
  );

  // The shared ALU itself.
  always_comb begin
    case (sel)
      3'b000:  alu_res = d1;
      3'b001:  alu_res = d1 + d2;
      3'b010:  alu_res = d1 & d2;
      3'b011:  alu_res = d1 | d2;
      default: alu_res = 8'h00;
    endcase
  end

  function automatic logic [7:0] ref_res(
    input logic [2:0] o, input logic [7:0] a, b);
    int s;
    if (o >= 3'd4) return 8'h00;
    if (o == 3'd0) return a;
    if (o == 3'd2) return a & b;
    if (o == 3'd3) return a | b;
    s = (int'(a) + int'(b)) % 256;
    return 8'(s);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r,
                       input logic [2:0] o,
                       input logic [7:0] a, b);
    if (i == 0) begin
      req0 = r; op0 = o; a0 = a; b0 = b;
    end else begin
      req1 = r; op1 = o; a1 = a; b1 = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t tv[8];

  // Randomized-run state.
  logic       rq[2];
  logic [2:0] sop[2];
  logic [7:0] sa[2];
  logic [7:0] sb[2];
  int         waitc[2];

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g, v, pg, pv, preq, elig, expg;
    logic       last;
    logic [3:0] pat[8];

    rst = 1'b1;
    drive(0, 1'b1, 3'b011, 8'hA5, 8'h0F);
    drive(1, 1'b0, 3'b000, 8'h00, 8'h00);

    // Reset holds everything quiet even with a request pending.
    tick();
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_valid", {valid1, valid0}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sel", sel, 3'b000);
    chk("rst_res", res_out, 8'h00);
    drive(0, 1'b0, 3'b000, 8'h00, 8'h00);
    rst = 1'b0;
    tick();

    tv[0] = '{0, 3'b011, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    tv[1] = '{1, 3'b001, 8'hFF, 8'h02, 8'h01, 1'b0};
    tv[2] = '{0, 3'b101, 8'h12, 8'h34, 8'h00, 1'b1};
    tv[3] = '{0, 3'b000, 8'h3C, 8'h99, 8'h3C, 1'b0};
    tv[4] = '{1, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tv[5] = '{1, 3'b111, 8'h55, 8'h55, 8'h00, 1'b1};
    tv[6] = '{0, 3'b001, 8'h7F, 8'h01, 8'h80, 1'b0};
    tv[7] = '{1, 3'b011, 8'h00, 8'h00, 8'h00, 1'b0};

    foreach (tv[k]) begin
      logic [1:0] gid;
      logic [2:0] xsel;
      gid  = (tv[k].id == 0) ? 2'b01 : 2'b10;
      xsel = tv[k].op[2] ? 3'b000 : tv[k].op;
      drive(tv[k].id, 1'b1, tv[k].op, tv[k].a, tv[k].b);
      tick();
      chk($sformatf("v%0d_gnt", k), {gnt1, gnt0}, gid);
      chk($sformatf("v%0d_busy", k), busy, 1'b1);
      chk($sformatf("v%0d_sel", k), sel, xsel);
      // Operands wiggle during GNT; latched copies must win.
      drive(tv[k].id, 1'b1, ~tv[k].op, ~tv[k].a, 8'h5A);
      tick();
      chk($sformatf("v%0d_valid", k), {valid1, valid0}, gid);
      chk($sformatf("v%0d_res", k), res_out, tv[k].res);
      chk($sformatf("v%0d_err", k), err, tv[k].err);
      drive(tv[k].id, 1'b0, 3'b000, 8'h00, 8'h00);
      tick();
      chk($sformatf("v%0d_idle", k),
          {busy, valid1, valid0}, 3'b000);
    end

    // Both requesting from reset, held: grants alternate.
    do_reset();
    drive(0, 1'b1, 3'b001, 8'h7F, 8'h01);
    drive(1, 1'b1, 3'b010, 8'hF0, 8'h3C);
    // {valid1, valid0, gnt1, gnt0} per cycle
    pat = '{4'b0001, 4'b0100, 4'b0010, 4'b1000,
            4'b0001, 4'b0100, 4'b0010, 4'b1000};
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("rr_c%0d", c),
          {valid1, valid0, gnt1, gnt0}, pat[c]);
      if (valid0) chk("rr_res0", res_out, 8'h80);
      if (valid1) chk("rr_res1", res_out, 8'h30);
    end
    drive(0, 1'b0, 3'b000, 8'h00, 8'h00);
    drive(1, 1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    tick();

    // Reset mid-EXEC discards the op; held REQ0 is re-served.
    do_reset();
    drive(0, 1'b1, 3'b001, 8'h12, 8'h34);
    tick();
    chk("mid_gnt", gnt0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_drop", {busy, gnt1, gnt0}, 3'b000);
    tick();
    chk("mid_novalid", {valid1, valid0}, 2'b00);
    rst = 1'b0;
    tick();
    chk("mid_regnt", gnt0, 1'b1);
    tick();
    chk("mid_valid", valid0, 1'b1);
    chk("mid_res", res_out, 8'h46);
    drive(0, 1'b0, 3'b000, 8'h00, 8'h00);
    tick();

    // Randomized run against a transaction-level model.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; sop[i] = '0; sa[i] = '0; sb[i] = '0;
      waitc[i] = 0;
    end
    pg = 2'b00; pv = 2'b00; preq = 2'b00;
    last = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      g = {gnt1, gnt0};
      v = {valid1, valid0};
      chk("r_valid", v, pg);
      if (pg != 2'b00)
        expg = 2'b00;
      else begin
        elig = preq & ~pv;
        if (elig == 2'b11)
          expg = last ? 2'b01 : 2'b10;
        else
          expg = elig;
      end
      chk("r_gnt", g, expg);
      if (g != 2'b00) last = g[1];
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          chk("r_res", res_out, ref_res(sop[i], sa[i], sb[i]));
          chk("r_err", err, sop[i][2]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          rq[i] = 1'b0;
        end else if (!rq[i] && ($urandom % 3 == 0)) begin
          rq[i]  = 1'b1;
          sop[i] = 3'($urandom % 8);
          sa[i]  = 8'($urandom);
          sb[i]  = 8'($urandom);
        end
        if (rq[i] && !g[i] && !v[i]) waitc[i]++;
        else waitc[i] = 0;
        if (rq[i]) chk("r_wait", waitc[i] <= 4, 1'b1);
        if (g[i])
          drive(i, rq[i], 3'($urandom), 8'($urandom),
                8'($urandom));
        else
          drive(i, rq[i], sop[i], sa[i], sb[i]);
      end
      pg   = g;
      pv   = v;
      preq = {rq[1], rq[0]};
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
